// File: rtl/uart_apb_seq_pkg.sv
// Shared constants for the UART APB sequencer: CoreUARTapb register map,
// FSM state encoding and err_sticky bit positions.
package uart_apb_seq_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;

  localparam int ERR_PARITY   = 0;
  localparam int ERR_FRAMING  = 1;
  localparam int ERR_OVERFLOW = 2;

  typedef enum logic [2:0] {
    INIT1,
    INIT2,
    IDLE,
    SETUP,
    ACCESS,
    GUARD
  } state_e;

  // Which transfer occupies the SETUP/ACCESS pair; decides where ACCESS exits to.
  typedef enum logic [1:0] {
    OP_CFG1,
    OP_CFG2,
    OP_TX,
    OP_RX
  } op_e;

endpackage

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a CoreUARTapb at start-up, then moves bytes between
// valid/ready TX/RX streams and the UART data registers, with sticky error flags.
module uart_apb_sequencer
  import uart_apb_seq_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'b00
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       TXRDY,
  input  logic       RXRDY,
  input  logic       PARITY_ERR,
  input  logic       FRAMING_ERR,
  input  logic       OVERFLOW,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [2:0] err_sticky,
  input  logic       err_clr,
  output logic       cfg_done
);

  state_e     state_q, state_d;
  op_e        op_q;
  logic       last_rx_q;
  logic       guard_q;
  logic       tx_req, rx_req;
  logic       tx_grant, rx_grant;
  logic       xfer_done;
  logic [2:0] err_set;

  assign tx_req    = tx_valid & TXRDY;
  assign rx_req    = RXRDY & ~rx_valid;
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign xfer_done = PENABLE & PREADY;
  assign tx_ready  = tx_grant;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    err_set               = '0;
    err_set[ERR_PARITY]   = PARITY_ERR;
    err_set[ERR_FRAMING]  = FRAMING_ERR;
    err_set[ERR_OVERFLOW] = OVERFLOW;
  end

  always_comb begin
    state_d  = state_q;
    tx_grant = 1'b0;
    rx_grant = 1'b0;
    case (state_q)
      INIT1:  state_d = SETUP;
      INIT2:  state_d = SETUP;
      IDLE: begin
        // last_rx_q set means RX went last, so TX wins a tie.
        if (tx_req && (!rx_req || last_rx_q)) tx_grant = 1'b1;
        else if (rx_req)                      rx_grant = 1'b1;
        if (tx_grant || rx_grant) state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          if (op_q == OP_CFG1)      state_d = INIT2;
          else if (op_q == OP_CFG2) state_d = IDLE;
          else                      state_d = GUARD;
        end
      end
      GUARD:  if (guard_q) state_d = IDLE;
      default: state_d = INIT1;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!PRESETN) state_q <= INIT1;
    else          state_q <= state_d;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      op_q       <= OP_CFG1;
      last_rx_q  <= 1'b1;
      guard_q    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      err_sticky <= '0;
      cfg_done   <= 1'b0;
    end else begin
      // Set is OR-ed in after the clear so a coincident error survives err_clr.
      err_sticky <= err_set | (err_clr ? 3'b000 : err_sticky);
      guard_q    <= (state_q == GUARD) ? ~guard_q : 1'b0;

      case (state_q)
        INIT1: begin
          PADDR  <= ADDR_CTRL1;
          PWDATA <= BAUD_VALUE[7:0];
          PWRITE <= 1'b1;
          op_q   <= OP_CFG1;
        end
        INIT2: begin
          PADDR  <= ADDR_CTRL2;
          PWDATA <= {BAUD_VALUE[12:8], PRG_PARITY, PRG_BIT8};
          PWRITE <= 1'b1;
          op_q   <= OP_CFG2;
        end
        IDLE: begin
          if (tx_grant) begin
            PADDR     <= ADDR_TXDATA;
            PWDATA    <= tx_data;
            PWRITE    <= 1'b1;
            op_q      <= OP_TX;
            last_rx_q <= 1'b0;
          end else if (rx_grant) begin
            PADDR     <= ADDR_RXDATA;
            PWRITE    <= 1'b0;
            op_q      <= OP_RX;
            last_rx_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (xfer_done) begin
        if (op_q == OP_CFG2) cfg_done <= 1'b1;
        if (op_q == OP_RX) begin
          rx_data  <= PRDATA;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Scoreboard bench for uart_apb_sequencer: stimulus queues expected APB transfers
// and RX bytes, a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_apb_sequencer;
  import uart_apb_seq_pkg::*;

  typedef struct {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
  } apb_t;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY, TXRDY, RXRDY;
  logic       PARITY_ERR, FRAMING_ERR, OVERFLOW;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [2:0] err_sticky;
  logic       err_clr;
  logic       cfg_done;

  uart_apb_sequencer #(
    .BAUD_VALUE(13'h123),
    .PRG_BIT8  (1'b1),
    .PRG_PARITY(2'b11)
  ) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .TXRDY      (TXRDY),
    .RXRDY      (RXRDY),
    .PARITY_ERR (PARITY_ERR),
    .FRAMING_ERR(FRAMING_ERR),
    .OVERFLOW   (OVERFLOW),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .cfg_done   (cfg_done)
  );

  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int tx_pulses   = 0;
  int xfers       = 0;
  int last_acc_len = 0;

  apb_t       exp_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_bytes[$];
  int         grant_cyc[$];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_apb(input logic [4:0] addr, input logic wr, input logic [7:0] data);
    apb_t e;
    e.addr = addr;
    e.wr   = wr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every completed APB transfer and RX handshake against the queues.
  initial begin : monitor
    logic [13:0] snap;
    int          acc_len;
    logic        cfg_prev;
    logic        ctrl2_prev;
    apb_t        e;
    logic [7:0]  r;
    snap = '0; acc_len = 0; cfg_prev = 1'b0; ctrl2_prev = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETN) begin
        cfg_prev   = 1'b0;
        ctrl2_prev = 1'b0;
      end else begin
        if (cfg_done && !cfg_prev) check("cfg_done_rise_after_ctrl2", 32'(ctrl2_prev), 32'd1);
        cfg_prev   = cfg_done;
        ctrl2_prev = 1'b0;
        if (tx_ready) begin
          tx_pulses++;
          if (!cfg_done) check("tx_ready_before_cfg_done", 32'(tx_ready), 32'd0);
        end
        if (PSEL && !PENABLE) begin
          snap    = {PADDR, PWRITE, PWDATA};
          acc_len = 0;
        end
        if (PSEL && PENABLE) begin
          acc_len++;
          check("apb_stable_in_access", 32'({PADDR, PWRITE, PWDATA}), 32'(snap));
          if (PREADY) begin
            xfers++;
            last_acc_len = acc_len;
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL apb_unexpected: addr 0x%0h write %0b, expected no transfer", PADDR, PWRITE);
            end else begin
              e = exp_q.pop_front();
              check("apb_addr", 32'(PADDR), 32'(e.addr));
              check("apb_write", 32'(PWRITE), 32'(e.wr));
              if (e.wr) check("apb_wdata", 32'(PWDATA), 32'(e.data));
            end
            if (PADDR == ADDR_CTRL2) begin
              check("cfg_done_low_during_ctrl2", 32'(cfg_done), 32'd0);
              ctrl2_prev = 1'b1;
            end
          end
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_data);
          end else begin
            r = exp_rx.pop_front();
            check("rx_data", 32'(rx_data), 32'(r));
          end
        end
      end
    end
  end

  // Runs the TX stream from tx_bytes until all expected APB transfers are seen.
  // PREADY is released once `stall` ACCESS cycles have been held off.
  task automatic run(input int bound, input int stall);
    int  sent   = 0;
    int  stalls = 0;
    bit  done   = 0;
    if (tx_bytes.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = tx_bytes[0];
    end
    for (int c = 0; c < bound; c++) begin
      @(negedge PCLK);
      if (tx_ready && tx_valid) begin
        grant_cyc.push_back(cyc);
        sent++;
      end
      if (PSEL && PENABLE && !PREADY) stalls++;
      @(posedge PCLK);
      #1;
      if (sent >= tx_bytes.size()) tx_valid = 1'b0;
      else tx_data = tx_bytes[sent];
      if (stalls >= stall) PREADY = 1'b1;
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: %0d transfers outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int p0, x0;
    bit seen;
    PRESETN = 1'b0;
    PRDATA = 8'h00; PREADY = 1'b1; TXRDY = 1'b1; RXRDY = 1'b0;
    PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h55; rx_ready = 1'b0; err_clr = 1'b0;

    // Reset state, with a TX byte already waiting.
    repeat (2) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);

    // Start-up config (CTRL1=0x23, CTRL2=0x0F) then two TX bytes 5 cycles apart.
    push_apb(ADDR_CTRL1, 1'b1, 8'h23);
    push_apb(ADDR_CTRL2, 1'b1, 8'h0F);
    push_apb(ADDR_TXDATA, 1'b1, 8'h55);
    push_apb(ADDR_TXDATA, 1'b1, 8'hAA);
    tx_bytes = '{8'h55, 8'hAA};
    grant_cyc.delete();
    p0 = tx_pulses;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    run(60, 0);
    check("cfg_done_high", 32'(cfg_done), 32'd1);
    check("tx_pulse_count", 32'(tx_pulses - p0), 32'd2);
    if (grant_cyc.size() == 2) check("tx_spacing", 32'(grant_cyc[1] - grant_cyc[0]), 32'd5);
    else check("tx_grant_count", 32'(grant_cyc.size()), 32'd2);
    tick(3);

    // RX held: one read, rx_data stays 0x3C while rx_ready is low.
    tx_bytes.delete();
    PRDATA = 8'h3C; RXRDY = 1'b1;
    push_apb(ADDR_RXDATA, 1'b0, 8'h00);
    exp_rx.push_back(8'h3C);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (rx_valid) begin
        seen = 1;
        break;
      end
    end
    check("rx_valid_rise", 32'(seen), 32'd1);
    PRDATA = 8'hFF;
    x0 = xfers;
    tick(10);
    check("rx_no_extra_reads", 32'(xfers), 32'(x0));
    check("rx_valid_held", 32'(rx_valid), 32'd1);
    check("rx_data_held", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1; RXRDY = 1'b0;
    tick(1);
    rx_ready = 1'b0;
    check("rx_valid_cleared", 32'(rx_valid), 32'd0);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    tick(2);

    // TX and RX both pending: grants alternate TX, RX, TX, RX.
    PRDATA = 8'h5A; RXRDY = 1'b1; rx_ready = 1'b1;
    tx_bytes = '{8'h11, 8'h22};
    push_apb(ADDR_TXDATA, 1'b1, 8'h11);
    push_apb(ADDR_RXDATA, 1'b0, 8'h00);
    push_apb(ADDR_TXDATA, 1'b1, 8'h22);
    push_apb(ADDR_RXDATA, 1'b0, 8'h00);
    exp_rx.push_back(8'h5A);
    exp_rx.push_back(8'h5A);
    run(80, 0);
    RXRDY = 1'b0;
    tick(4);
    rx_ready = 1'b0;
    check("mixed_rx_drained", 32'(exp_rx.size()), 32'd0);

    // PREADY low for 3 ACCESS cycles: transfer held stable for 4 ACCESS cycles.
    tx_bytes = '{8'hC3};
    push_apb(ADDR_TXDATA, 1'b1, 8'hC3);
    PREADY = 1'b0;
    run(40, 3);
    check("stall_access_len", 32'(last_acc_len), 32'd4);
    tick(3);

    // Sticky errors: set wins over a coincident clear.
    FRAMING_ERR = 1'b1; err_clr = 1'b1;
    tick(1);
    FRAMING_ERR = 1'b0; err_clr = 1'b0;
    check("err_set_wins", 32'(err_sticky), 32'b010);
    tick(2);
    check("err_sticky_holds", 32'(err_sticky), 32'b010);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clear", 32'(err_sticky), 32'b000);
    PARITY_ERR = 1'b1; OVERFLOW = 1'b1;
    tick(1);
    PARITY_ERR = 1'b0; OVERFLOW = 1'b0;
    check("err_parity_overflow", 32'(err_sticky), 32'b101);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // Reset during a TX ACCESS: bus drops at once, config reruns from CTRL1.
    PREADY = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        seen = 1;
        break;
      end
      if (tx_ready) begin
        @(posedge PCLK); #1;
        tx_valid = 1'b0;
      end
    end
    check("reach_tx_access", 32'(seen), 32'd1);
    #1;
    PRESETN = 1'b0;
    #1;
    check("abort_psel", 32'(PSEL), 32'd0);
    check("abort_penable", 32'(PENABLE), 32'd0);
    check("abort_pwdata", 32'(PWDATA), 32'd0);
    check("abort_cfg_done", 32'(cfg_done), 32'd0);
    tx_valid = 1'b0;
    PREADY = 1'b1;
    exp_q.delete();
    tx_bytes.delete();
    push_apb(ADDR_CTRL1, 1'b1, 8'h23);
    push_apb(ADDR_CTRL2, 1'b1, 8'h0F);
    tick(2);
    PRESETN = 1'b1;
    run(40, 0);
    check("reconfig_cfg_done", 32'(cfg_done), 32'd1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
